// File: rtl/shift_rotate_seq_pkg.sv
// Shared constants and state encoding for the shift/rotate sequencer.
package shift_rotate_seq_pkg;

   localparam int DW = 16;
   localparam int AW = 5;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/shift_rotate_seq_shifter.sv
// Combinational 16-bit barrel shifter: lr=1 shifts left, lr=0 shifts right, zero fill.
module Shift_16bit (
   input  logic [15:0] in,
   input  logic [3:0]  shift,
   input  logic        lr,
   output logic [15:0] out
);

   assign out = lr ? (in << shift) : (in >> shift);

endmodule

// File: rtl/shift_rotate_seq.sv
// Sequencer around Shift_16bit: logical shifts in one pass, rotates in two passes
// whose partial results are OR-ed together, result held under valid/ready.
module shift_rotate_seq
   import shift_rotate_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [DW-1:0] cmd_data,
   input  logic [AW-1:0] cmd_amt,
   input  logic          cmd_lr,
   input  logic          cmd_rot,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and res_data is held while
   // res_valid is high and res_ready is low.

   state_t        state;
   logic [DW-1:0] data_q;
   logic [AW-1:0] amt_q;
   logic          lr_q;
   logic          rot_q;
   logic [DW-1:0] partial_q;

   logic [3:0]    sh_shift;
   logic          sh_lr;
   logic [DW-1:0] sh_out;
   logic          accept;

   // Second rotate pass moves the wrapped bits the other way by 16-k.
   assign sh_shift = (state == ST_PASS2) ? (4'd0 - amt_q[3:0]) : amt_q[3:0];
   assign sh_lr    = (state == ST_PASS2) ? ~lr_q : lr_q;

   Shift_16bit u_shift (
      .in    (data_q),
      .shift (sh_shift),
      .lr    (sh_lr),
      .out   (sh_out)
   );

   assign cmd_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && res_ready));
   assign accept    = cmd_valid && cmd_ready;
   assign res_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         data_q    <= '0;
         amt_q     <= '0;
         lr_q      <= 1'b0;
         rot_q     <= 1'b0;
         partial_q <= '0;
         res_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  data_q <= cmd_data;
                  amt_q  <= cmd_amt;
                  lr_q   <= cmd_lr;
                  rot_q  <= cmd_rot;
                  state  <= ST_PASS1;
               end
            end
            ST_PASS1: begin
               if (!rot_q) begin
                  // Logical amounts of 16 or more push every bit out.
                  res_data <= amt_q[AW-1] ? '0 : sh_out;
                  state    <= ST_DONE;
               end else if (amt_q[3:0] == 4'd0) begin
                  res_data <= data_q;
                  state    <= ST_DONE;
               end else begin
                  partial_q <= sh_out;
                  state     <= ST_PASS2;
               end
            end
            ST_PASS2: begin
               res_data <= partial_q | sh_out;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (res_ready) begin
                  if (accept) begin
                     data_q <= cmd_data;
                     amt_q  <= cmd_amt;
                     lr_q   <= cmd_lr;
                     rot_q  <= cmd_rot;
                     state  <= ST_PASS1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed and randomised checks of shift_rotate_seq against a reference shift/rotate model.
module tb_shift_rotate_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data;
   logic [4:0]  cmd_amt;
   logic        cmd_lr;
   logic        cmd_rot;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        busy;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   shift_rotate_seq dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_amt   (cmd_amt),
      .cmd_lr    (cmd_lr),
      .cmd_rot   (cmd_rot),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [15:0] d, input logic [4:0] a,
                                         input logic l, input logic r);
      logic [31:0] dd;
      dd = {d, d};
      if (r) begin
         if (l) begin
            dd = dd << a[3:0];
            return dd[31:16];
         end else begin
            dd = dd >> a[3:0];
            return dd[15:0];
         end
      end
      if (a >= 5'd16) return 16'h0000;
      return l ? (d << a) : (d >> a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from IDLE with res_ready high, measure latency in edges
   // (accept edge inclusive) and check the result.
   task automatic run_cmd(input string tag, input logic [15:0] d, input logic [4:0] a,
                          input logic l, input logic r, input logic [15:0] exp, input int lat);
      int n;
      cmd_data  = d;
      cmd_amt   = a;
      cmd_lr    = l;
      cmd_rot   = r;
      cmd_valid = 1'b1;
      #1;
      check({tag, "_ready"}, cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 10) begin
         check({tag, "_busy"}, busy, 1);
         tick();
         n++;
      end
      check({tag, "_lat"}, n, lat);
      check({tag, "_data"}, res_data, exp);
      tick();
      check({tag, "_idle"}, dbg_state, 0);
   endtask

   initial begin : stim
      int n;
      int sent;
      int got;
      int cyc;
      logic acc;
      logic [15:0] e;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_amt   = '0;
      cmd_lr    = 1'b0;
      cmd_rot   = 1'b0;
      res_ready = 1'b1;
      #3;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_ready", cmd_ready, 1);

      // directed vectors
      run_cmd("lsl4",    16'h00F1, 5'd4,  1'b1, 1'b0, 16'h0F10, 2);
      run_cmd("lsr15",   16'h8001, 5'd15, 1'b0, 1'b0, 16'h0001, 2);
      run_cmd("lsr20",   16'h8001, 5'd20, 1'b0, 1'b0, 16'h0000, 2);
      run_cmd("lsl16",   16'hFFFF, 5'd16, 1'b1, 1'b0, 16'h0000, 2);
      run_cmd("lsl0",    16'hA5C3, 5'd0,  1'b1, 1'b0, 16'hA5C3, 2);
      run_cmd("rol1",    16'h8001, 5'd1,  1'b1, 1'b1, 16'h0003, 3);
      run_cmd("ror4",    16'h1234, 5'd4,  1'b0, 1'b1, 16'h4123, 3);
      run_cmd("rot16",   16'h1234, 5'd16, 1'b1, 1'b1, 16'h1234, 2);
      run_cmd("ror0",    16'h1234, 5'd0,  1'b0, 1'b1, 16'h1234, 2);
      run_cmd("rol20",   16'h1234, 5'd20, 1'b1, 1'b1, 16'h2341, 3);
      run_cmd("ror15",   16'h0001, 5'd15, 1'b0, 1'b1, 16'h0002, 3);

      // backpressure: result held for 5 cycles, then back-to-back accept
      res_ready = 1'b0;
      cmd_data  = 16'h00F1;
      cmd_amt   = 5'd8;
      cmd_lr    = 1'b1;
      cmd_rot   = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", res_valid, 1);
         check("bp_data", res_data, 16'hF100);
         check("bp_ready", cmd_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      cmd_data  = 16'h1234;
      cmd_amt   = 5'd8;
      cmd_lr    = 1'b0;
      cmd_rot   = 1'b1;
      cmd_valid = 1'b1;
      #1;
      check("b2b_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check("b2b_drop", res_valid, 0);
      check("b2b_state", dbg_state, 1);
      n = 1;
      while (!res_valid && n < 10) begin
         tick();
         n++;
      end
      check("b2b_lat", n, 3);
      check("b2b_data", res_data, 16'h3412);
      tick();

      // asynchronous reset during PASS2 of a rotate
      cmd_data  = 16'h8001;
      cmd_amt   = 5'd1;
      cmd_lr    = 1'b1;
      cmd_rot   = 1'b1;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("ar_in_pass2", dbg_state, 2);
      #2;
      rst = 1'b1;
      #1;
      check("ar_res_valid", res_valid, 0);
      check("ar_res_data", res_data, 0);
      check("ar_cmd_ready", cmd_ready, 0);
      check("ar_state", dbg_state, 0);
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("ar_rel_ready", cmd_ready, 1);
      check("ar_rel_state", dbg_state, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ar_no_stale", res_valid, 0);
      end

      // randomised regression with res_ready stalls
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 2000 && cyc < 40000) begin
         if (!cmd_valid && sent < 2000) begin
            cmd_data  = 16'($urandom_range(0, 65535));
            cmd_amt   = 5'($urandom_range(0, 31));
            cmd_lr    = 1'($urandom_range(0, 1));
            cmd_rot   = 1'($urandom_range(0, 1));
            cmd_valid = 1'b1;
         end
         res_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = cmd_valid && cmd_ready;
         if (acc) begin
            exp_q.push_back(model(cmd_data, cmd_amt, cmd_lr, cmd_rot));
            sent++;
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rand_data", res_data, e);
            end
            got++;
         end
         tick();
         if (acc) cmd_valid = 1'b0;
         cyc++;
      end
      check("rand_count", got, 2000);
      check("rand_leftover", exp_q.size(), 0);
      tick();
      check("rand_final_idle", res_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_rotate_seq.md
Name: shift_rotate_seq

Overview:
- Sequencing stage directly upstream of the combinational 16-bit barrel shifter `Shift_16bit`.
- Accepts shift/rotate commands over a valid/ready handshake and drives the shifter's `shift`, `lr` and `in` inputs.
- Runs one or two shifter passes per command, combining the two partial results for rotates.
- Registers the final word and presents it downstream with valid/ready backpressure, adding rotate and over-shift support that the shifter lacks.

Parameters:
- DW, 16, data width; only 16 is supported (matches the shifter).
- AW, 5, command amount width; amounts 0..31.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_data  input  DW  operand word.
- cmd_amt  input  AW  shift/rotate amount.
- cmd_lr  input  1  1 = left, 0 = right (same sense as the shifter's `lr`).
- cmd_rot  input  1  1 = rotate, 0 = logical shift (zero fill).
- res_valid  output  1  result held.
- res_ready  input  1  downstream accepts the result.
- res_data  output  DW  result word.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset: asynchronous and active-high; one clock; all state clears on assertion.
  - state=IDLE; res_valid=0, res_data=0, busy=0.
  - cmd_ready=0 while rst is high, and 1 in the first cycle after release.
  - Internal work and partial registers clear to 0.
  - Any in-flight command is dropped; no stale result appears after release.
- States are IDLE, PASS1, PASS2 and DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch data, amt, lr and rot, then go to PASS1.
- PASS1 (shifter `in`=latched data):
  - Logical, amt<16: shifter gets shift=amt[3:0], lr=cmd_lr. res_data<=shifter out, then go to DONE.
  - Logical, amt>=16: res_data<=16'h0000, then go to DONE. The shifter output is ignored.
  - Rotate, k=amt[3:0]=0 (amt 0 or 16): res_data<=data, then go to DONE.
  - Rotate, k!=0: shifter gets shift=k, lr=cmd_lr. partial<=shifter out, then go to PASS2.
- PASS2 (rotate only):
  - Shifter gets in=latched data, shift=16-k (4-bit, 1..15), lr=~cmd_lr.
  - res_data<=partial | shifter out, then go to DONE.
- DONE:
  - res_valid=1; res_data is held stable until res_ready.
  - On res_ready: go to IDLE, and res_valid drops next cycle.
  - cmd_ready=res_ready in DONE. A simultaneous cmd_valid is accepted on the same edge, going straight to PASS1 (back-to-back).
- Latency, counted from the accept edge to res_valid high:
  - 2 cycles for logical commands and rotates with k=0.
  - 3 cycles for rotates with k!=0.
- Throughput: one command per 2 cycles (single-pass) or 3 cycles (two-pass), given res_ready held high.
- cmd_ready is 0 in PASS1 and PASS2. cmd_data, cmd_amt, cmd_lr and cmd_rot are don't-care when no accept occurs.
- Width rules:
  - Amount truncates mod 16 for rotates.
  - Logical amounts 16..31 saturate to an all-zero result.
  - No sign extension; right shifts are logical.
- res_data changes only on the PASS1→DONE or PASS2→DONE transition.

Decomposition:
- Shared package holds:
  - DW=16 and AW=5 constants.
  - State encoding constants ST_IDLE=0, ST_PASS1=1, ST_PASS2=2, ST_DONE=3.
  - Direction constants DIR_LEFT=1, DIR_RIGHT=0.
- One sub-module: instantiate the existing `Shift_16bit` once, time-shared between PASS1 and PASS2.
- No other hierarchy is needed; the FSM, operand registers, partial register and result register live in shift_rotate_seq.

Test Plan:
- Logical left: data 16'h00F1, amt 4, lr=1, rot=0 → res_data 16'h0F10; res_valid exactly 2 cycles after accept; busy high in between.
- Logical right and over-shift:
  - 16'h8001, amt 15, lr=0 → 16'h0001.
  - 16'h8001, amt 20, lr=0 → 16'h0000, with 2-cycle latency.
- Rotates:
  - 16'h8001, amt 1, lr=1, rot=1 → 16'h0003, 3-cycle latency.
  - 16'h1234, amt 4, lr=0, rot=1 → 16'h4123.
  - 16'h1234, amt 16, rot=1 → 16'h1234, 2-cycle latency.
- Backpressure:
  - Hold res_ready=0 for 5 cycles in DONE → res_data and res_valid stable, cmd_ready=0.
  - Then res_ready=1 with cmd_valid=1 in the same cycle → new command accepted on that edge; the next result follows with normal latency.
- Reset mid-operation: assert rst asynchronously during PASS2 of a rotate → res_valid=0, res_data=0 immediately, cmd_ready=0 while rst is high. After release, state=IDLE, cmd_ready=1, and no result for the dropped command ever appears.
- Random regression: 2000 random commands with random res_ready stalls → every result matches a software shift/rotate model, in order, with no loss or duplication.
